// File: rtl/cop0_pkg.sv
// Shared COP0 definitions: register indices, Status/Cause bit positions
// and exception codes.
package cop0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam int SR_IE     = 0;
    localparam int SR_EL     = 1;
    localparam int SR_UM     = 4;
    localparam int SR_IM_LO  = 8;

    localparam int CAUSE_SW_LO = 8;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cop0_timer.sv
// Count/Compare timer with a COUNT_DIV prescaler and a sticky timer
// pending flag that a Compare write clears.
module cop0_timer
    import cop0_pkg::*;
#(
    parameter int COUNT_DIV     = 2,
    parameter int WRAP_ON_MATCH = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pending
);

    localparam logic [7:0] PRESC_MAX = 8'(COUNT_DIV - 1);

    logic [7:0] presc;
    logic       tick;
    logic       match;

    // A Count write restarts the prescale period, so it masks the tick.
    assign tick  = (presc == PRESC_MAX) && !count_we;
    assign match = (count == compare);

    always_ff @(posedge clk) begin
        if (clr) begin
            presc         <= '0;
            count         <= '0;
            compare       <= '0;
            timer_pending <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                presc <= '0;
            end else begin
                presc <= (presc == PRESC_MAX) ? 8'd0 : presc + 8'd1;
                if (tick) begin
                    count <= (match && WRAP_ON_MATCH != 0) ? 32'd0 : count + 32'd1;
                end
            end
            if (compare_we) begin
                compare <= wdata;
            end
            if (tick && match) begin
                timer_pending <= 1'b1;
            end else if (compare_we) begin
                timer_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cop0_regs_param.sv
// COP0 register file: Status, Cause, EPC, BadVAddr, exception/eret
// sequencing and interrupt masking around the cop0_timer block.
module cop0_regs_param
    import cop0_pkg::*;
#(
    parameter int          NUM_IRQ       = 8,
    parameter int          TIMER_LINE    = 2,
    parameter int          COUNT_DIV     = 2,
    parameter int          WRAP_ON_MATCH = 1,
    parameter logic [31:0] SR_RESET      = 32'h00000911
) (
    input  logic               iCLK,
    input  logic               iCLR,
    input  logic [4:0]         iReadRegister,
    output logic [31:0]        oReadData,
    input  logic [4:0]         iWriteRegister,
    input  logic [31:0]        iWriteData,
    input  logic               iRegWrite,
    input  logic               iEret,
    input  logic               iExcOccurred,
    input  logic               iBranchDelay,
    input  logic [4:0]         iExcCode,
    input  logic [31:0]        iExcPC,
    input  logic [31:0]        iBadVAddr,
    input  logic [NUM_IRQ-1:0] iPendingInterrupt,
    output logic [7:0]         oInterruptMask,
    output logic               oIrqRequest,
    output logic [31:0]        oEretTarget,
    output logic               oUserMode,
    output logic               oExcLevel,
    output logic               oInterruptEnable,
    input  logic [4:0]         iRegDispSelect,
    output logic [31:0]        oRegDisp
);

    logic [31:0]        status;
    logic [31:0]        epc;
    logic [31:0]        badvaddr;
    logic               bd;
    logic [4:0]         exc_code;
    logic [1:0]         sw_ip;
    logic [NUM_IRQ-1:0] hw_ip;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic               ti;
    logic               wr;
    logic [7:0]         ip;
    logic [31:0]        cause;
    logic [31:0]        view [32];

    // Exceptions and eret swallow any mtc0 issued in the same cycle.
    assign wr = iRegWrite && !iExcOccurred && !iEret;

    cop0_timer #(
        .COUNT_DIV     (COUNT_DIV),
        .WRAP_ON_MATCH (WRAP_ON_MATCH)
    ) u_timer (
        .clk           (iCLK),
        .clr           (iCLR),
        .count_we      (wr && iWriteRegister == REG_COUNT),
        .compare_we    (wr && iWriteRegister == REG_COMPARE),
        .wdata         (iWriteData),
        .count         (count),
        .compare       (compare),
        .timer_pending (ti)
    );

    always_comb begin
        ip             = 8'(hw_ip);
        ip[TIMER_LINE] = ip[TIMER_LINE] | ti;
        ip[1:0]        = ip[1:0] | sw_ip;
    end

    assign cause = {bd, 15'd0, ip, 1'b0, exc_code, 2'b00};

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            view[i] = '0;
        end
        view[REG_BADVADDR] = badvaddr;
        view[REG_COUNT]    = count;
        view[REG_COMPARE]  = compare;
        view[REG_STATUS]   = status;
        view[REG_CAUSE]    = cause;
        view[REG_EPC]      = epc;
    end

    assign oReadData = view[iReadRegister];
    assign oRegDisp  = view[iRegDispSelect];

    always_ff @(posedge iCLK) begin
        if (iCLR) begin
            status   <= SR_RESET;
            epc      <= '0;
            badvaddr <= '0;
            bd       <= 1'b0;
            exc_code <= '0;
            sw_ip    <= '0;
            hw_ip    <= '0;
        end else begin
            hw_ip <= iPendingInterrupt;
            if (iExcOccurred) begin
                status[SR_EL] <= 1'b1;
                status[SR_UM] <= 1'b0;
                bd            <= iBranchDelay;
                exc_code      <= iExcCode;
                epc           <= iExcPC;
                if (is_addr_exc(iExcCode)) begin
                    badvaddr <= iBadVAddr;
                end
            end else if (iEret) begin
                status[SR_EL] <= 1'b0;
                status[SR_UM] <= 1'b1;
            end else if (wr) begin
                unique case (iWriteRegister)
                    REG_STATUS: status <= iWriteData;
                    REG_CAUSE:  sw_ip  <= iWriteData[CAUSE_SW_LO +: 2];
                    REG_EPC:    epc    <= iWriteData;
                    default: ;
                endcase
            end
        end
    end

    assign oInterruptMask   = (status[SR_IE] && !status[SR_EL])
                            ? (status[SR_IM_LO +: 8] & ip) : 8'd0;
    assign oIrqRequest      = |oInterruptMask;
    assign oEretTarget      = epc;
    assign oUserMode        = status[SR_UM];
    assign oExcLevel        = status[SR_EL];
    assign oInterruptEnable = status[SR_IE];

endmodule

// File: tb/tb_cop0_regs_param.sv
// Directed bench: u_w wraps Count on match, u_f is free-running.
module tb_cop0_regs_param;

    logic        iCLK = 1'b0;
    logic        iCLR;
    logic [4:0]  iReadRegister;
    logic [4:0]  iWriteRegister;
    logic [31:0] iWriteData;
    logic        iRegWrite;
    logic        iEret;
    logic        iExcOccurred;
    logic        iBranchDelay;
    logic [4:0]  iExcCode;
    logic [31:0] iExcPC;
    logic [31:0] iBadVAddr;
    logic [7:0]  iPendingInterrupt;
    logic [4:0]  iRegDispSelect;

    logic [31:0] rd_w, disp_w, tgt_w, rd_f, disp_f, tgt_f;
    logic [7:0]  msk_w, msk_f;
    logic        irq_w, um_w, el_w, ie_w, irq_f, um_f, el_f, ie_f;

    int n_vec = 0;
    int n_bad = 0;

    always #5 iCLK = ~iCLK;

    cop0_regs_param #(.WRAP_ON_MATCH(1)) u_w (
        .iCLK(iCLK), .iCLR(iCLR), .iReadRegister(iReadRegister), .oReadData(rd_w),
        .iWriteRegister(iWriteRegister), .iWriteData(iWriteData), .iRegWrite(iRegWrite),
        .iEret(iEret), .iExcOccurred(iExcOccurred), .iBranchDelay(iBranchDelay),
        .iExcCode(iExcCode), .iExcPC(iExcPC), .iBadVAddr(iBadVAddr),
        .iPendingInterrupt(iPendingInterrupt), .oInterruptMask(msk_w), .oIrqRequest(irq_w),
        .oEretTarget(tgt_w), .oUserMode(um_w), .oExcLevel(el_w), .oInterruptEnable(ie_w),
        .iRegDispSelect(iRegDispSelect), .oRegDisp(disp_w)
    );

    cop0_regs_param #(.WRAP_ON_MATCH(0)) u_f (
        .iCLK(iCLK), .iCLR(iCLR), .iReadRegister(iReadRegister), .oReadData(rd_f),
        .iWriteRegister(iWriteRegister), .iWriteData(iWriteData), .iRegWrite(iRegWrite),
        .iEret(iEret), .iExcOccurred(iExcOccurred), .iBranchDelay(iBranchDelay),
        .iExcCode(iExcCode), .iExcPC(iExcPC), .iBadVAddr(iBadVAddr),
        .iPendingInterrupt(iPendingInterrupt), .oInterruptMask(msk_f), .oIrqRequest(irq_f),
        .oEretTarget(tgt_f), .oUserMode(um_f), .oExcLevel(el_f), .oInterruptEnable(ie_f),
        .iRegDispSelect(iRegDispSelect), .oRegDisp(disp_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic sel(input logic [4:0] idx);
        iReadRegister  = idx;
        iRegDispSelect = idx;
        #1;
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] d);
        iRegWrite      = 1'b1;
        iWriteRegister = idx;
        iWriteData     = d;
        cyc(1);
        iRegWrite      = 1'b0;
    endtask

    task automatic do_reset();
        iCLR = 1'b1;
        cyc(1);
        iCLR = 1'b0;
    endtask

    initial begin
        iCLR = 1'b0; iReadRegister = 0; iRegDispSelect = 0;
        iWriteRegister = 0; iWriteData = 0; iRegWrite = 0;
        iEret = 0; iExcOccurred = 0; iBranchDelay = 0; iExcCode = 0;
        iExcPC = 0; iBadVAddr = 0; iPendingInterrupt = 0;

        // Reset state
        do_reset();
        sel(5'd12); chk("rst_status", rd_w, 32'h00000911);
        sel(5'd13); chk("rst_cause", rd_w, 32'h0);
        sel(5'd9);  chk("rst_count", rd_w, 32'h0);
        chk("rst_flags", {28'd0, um_w, el_w, ie_w, irq_w}, 32'h0000000A);
        chk("rst_mask", {24'd0, msk_w}, 32'h0);
        chk("rst_eret", tgt_w, 32'h0);

        // Count reaches Compare=5 at edge 10, matches at edge 12
        do_reset();
        mtc0(5'd11, 32'd5);
        cyc(9);
        sel(5'd9);  chk("cnt_e10_w", rd_w, 32'd5);
        chk("cnt_e10_f", rd_f, 32'd5);
        sel(5'd13); chk("ti_e10", rd_w, 32'h0);
        cyc(2);
        sel(5'd9);  chk("cnt_e12_w", rd_w, 32'd0);
        chk("cnt_e12_f", disp_f, 32'd6);
        sel(5'd13); chk("ti_e12_w", rd_w, 32'h00000400);
        chk("ti_e12_f", rd_f, 32'h00000400);

        // Timer interrupt then Compare write clears it
        mtc0(5'd12, 32'h0000FF01);
        chk("irq_on", {23'd0, irq_w, msk_w}, 32'h00000104);
        mtc0(5'd11, 32'h20);
        chk("irq_off", {23'd0, irq_w, msk_w}, 32'h0);

        // Exception beats eret and mtc0 in the same cycle
        iExcOccurred = 1; iEret = 1; iRegWrite = 1;
        iWriteRegister = 5'd12; iWriteData = 32'h0;
        iExcCode = 5'd4; iExcPC = 32'h00400020; iBadVAddr = 32'h3; iBranchDelay = 1;
        cyc(1);
        iExcOccurred = 0; iEret = 0; iRegWrite = 0; iBranchDelay = 0;
        chk("exc_flags", {30'd0, um_w, el_w}, 32'h1);
        chk("exc_epc", tgt_w, 32'h00400020);
        sel(5'd8);  chk("exc_bva", rd_w, 32'h3);
        sel(5'd12); chk("exc_sr", rd_w, 32'h0000FF03);
        sel(5'd13); chk("exc_cause", rd_w, 32'h80000010);

        // Non-address exception leaves BadVAddr
        iExcOccurred = 1; iExcCode = 5'd8; iExcPC = 32'h100; iBadVAddr = 32'hDEAD;
        cyc(1);
        iExcOccurred = 0;
        sel(5'd8);  chk("sys_bva", disp_w, 32'h3);
        sel(5'd13); chk("sys_cause", rd_w, 32'h00000020);
        chk("sys_epc", tgt_w, 32'h100);

        // Interrupts masked while EL=1, visible after eret
        iPendingInterrupt = 8'h08;
        cyc(1);
        chk("el_mask", {24'd0, msk_w}, 32'h0);
        iEret = 1;
        cyc(1);
        iEret = 0;
        chk("eret_mask", {23'd0, irq_w, msk_w}, 32'h00000108);
        sel(5'd12); chk("eret_sr", rd_w, 32'h0000FF11);

        // Software interrupt bits, read-only/unimplemented indices
        mtc0(5'd13, 32'hFFFFFFFF);
        mtc0(5'd8, 32'h12345678);
        mtc0(5'd3, 32'hFFFFFFFF);
        sel(5'd13); chk("sw_cause", rd_w, 32'h00000B20);
        chk("sw_mask", {24'd0, msk_w}, 32'h0000000B);
        sel(5'd8);  chk("bva_ro", rd_w, 32'h3);
        sel(5'd3);  chk("unimpl", rd_w, 32'h0);

        // Count wrap FFFFFFFF -> 0, free-running past match
        iPendingInterrupt = 8'h00;
        do_reset();
        mtc0(5'd11, 32'h0);
        mtc0(5'd9, 32'hFFFFFFFF);
        cyc(2);
        sel(5'd9);  chk("wrap_f", rd_f, 32'h0);
        chk("wrap_w", rd_w, 32'h0);
        sel(5'd13); chk("wrap_ti_f", rd_f, 32'h0);
        cyc(2);
        sel(5'd9);  chk("match_cnt_f", rd_f, 32'h1);
        chk("match_cnt_w", rd_w, 32'h0);
        sel(5'd13); chk("match_ti_f", rd_f, 32'h00000400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cop0_regs_param.md
COP0_REGS_PARAM -- requirements
Module: cop0_regs_param

Interface
REQ-001 Parameters SHALL be: NUM_IRQ, default 8, hardware interrupt lines 1..8 mapped to Cause.IP[NUM_IRQ-1:0].
REQ-002 TIMER_LINE, default 2, IP bit ORed with the timer interrupt.
REQ-003 COUNT_DIV, default 2, iCLK cycles per Count tick, 1..256.
REQ-004 WRAP_ON_MATCH, default 1; 1 = Count returns to 0 on Compare match, 0 = free-running.
REQ-005 SR_RESET, default 32'h00000911, Status value after reset.
REQ-006 Ports, one per line:
 iCLK  in  1  sole clock, rising edge.
 iCLR  in  1  reset, synchronous, active-high.
 iReadRegister  in  5  COP0 read index.
 oReadData  out  32  combinational read data.
 iWriteRegister  in  5  COP0 write index.
 iWriteData  in  32  mtc0 data.
 iRegWrite  in  1  mtc0 strobe.
 iEret  in  1  eret strobe.
 iExcOccurred  in  1  exception strobe.
 iBranchDelay  in  1  faulting instruction in delay slot.
 iExcCode  in  5  Cause.ExcCode value.
 iExcPC  in  32  EPC value to capture.
 iBadVAddr  in  32  faulting address.
 iPendingInterrupt  in  NUM_IRQ  level hardware interrupts.
 oInterruptMask  out  8  enabled pending interrupts.
 oIrqRequest  out  1  OR of oInterruptMask.
 oEretTarget  out  32  EPC.
 oUserMode, oExcLevel, oInterruptEnable  out  1 each  SR[4], SR[1], SR[0].
 iRegDispSelect  in  5  debug display index; oRegDisp  out  32  debug data.

Function
REQ-007 Implemented indices SHALL be 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; other indices read 0 and ignore writes.
REQ-008 oReadData and oRegDisp SHALL be combinational from current register contents, same decode.
REQ-009 Prescaler SHALL count 0..COUNT_DIV-1; tick asserted on the cycle it equals COUNT_DIV-1, then wraps to 0.
REQ-010 On tick with Count==Compare: timer pending TI SHALL set; Count becomes 0 if WRAP_ON_MATCH else Count+1.
REQ-011 On tick without match Count SHALL become Count+1 modulo 2^32 (FFFFFFFF -> 0).
REQ-012 mtc0 to Count SHALL load iWriteData, clear the prescaler and suppress that cycle's tick.
REQ-013 mtc0 to Compare SHALL load iWriteData and clear TI; a same-cycle TI set SHALL win.
REQ-014 Cause.IP[i] SHALL register iPendingInterrupt[i] each cycle, with TI ORed into IP[TIMER_LINE]; IP bits above NUM_IRQ read 0.
REQ-015 oInterruptMask SHALL equal SR[15:8] AND Cause.IP when SR.IE=1 and SR.EL=0, else 0.
REQ-016 Exception SHALL, next edge: SR.EL=1, SR.UM=0, Cause.BD=iBranchDelay, Cause[6:2]=iExcCode, EPC=iExcPC.
REQ-017 Exception with iExcCode 4 or 5 SHALL also load BadVAddr from iBadVAddr; others leave it.
REQ-018 Eret SHALL, next edge: SR.EL=0, SR.UM=1; oEretTarget=EPC always.
REQ-019 Priority SHALL be iCLR > iExcOccurred > iEret > iRegWrite; lower-priority strobes in the same cycle are discarded.
REQ-020 Count/prescaler/TI update SHALL proceed in parallel with exception/eret/non-Count writes.
REQ-021 BadVAddr SHALL be read-only; Cause writes SHALL affect only bits [9:8] (software interrupts, ORed into IP[1:0]).

Reset
REQ-022 On iCLR at a rising edge: Count, Compare, Cause, EPC, BadVAddr, prescaler, TI = 0; Status = SR_RESET.
REQ-023 After reset: oInterruptMask=0, oIrqRequest=0, oEretTarget=0, oUserMode/oExcLevel/oInterruptEnable = SR_RESET bits 4/1/0.
REQ-024 iCLR mid-prescale SHALL discard the partial count; first tick occurs COUNT_DIV cycles after release.
REQ-025 No initial blocks or asynchronous edges off data signals SHALL be used.

Structure
REQ-026 Register indices, SR/Cause bit positions and ExcCode constants SHALL live in shared package cop0_pkg.
REQ-027 Count/Compare/prescaler/TI SHALL be sub-module cop0_timer; everything else in cop0_regs_param.

Verification
REQ-028 COUNT_DIV=2, Compare=5, reset release -> Count=5 at cycle 10, TI=1 at cycle 12, Count=0 (WRAP_ON_MATCH=1).
REQ-029 SR=0000FF01, TI set, mtc0 Compare=32'h20 -> oIrqRequest 1 then 0 one cycle after write.
REQ-030 iExcOccurred+iEret same cycle, iExcCode=4, iExcPC=400020, iBadVAddr=3 -> EL=1, EPC=400020, BadVAddr=3, UM=0.
REQ-031 Count=FFFFFFFF, Compare=0, WRAP_ON_MATCH=0 -> next tick Count=0; following tick TI=1, Count=1.
REQ-032 SR.EL=1, iPendingInterrupt=8'h08, SR.IM=FF -> oInterruptMask=0; after eret -> oInterruptMask=8'h08.
